// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state codes and the default flush depth.
package pipe_ctrl_pkg;

  localparam int FLUSH_DEPTH_DEFAULT = 2;

  typedef logic [2:0] state_code_t;

  localparam state_code_t S_IDLE  = 3'd0;
  localparam state_code_t S_RUN   = 3'd1;
  localparam state_code_t S_STALL = 3'd2;
  localparam state_code_t S_FLUSH = 3'd3;
  localparam state_code_t S_HALT  = 3'd4;
  localparam state_code_t S_STEP  = 3'd5;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side signals between the decode/fetch stages (master) and pipe_ctrl (slave).
interface pipe_ctrl_if;
  logic        halt_dec;
  logic        hazard;
  logic        pcsrc;
  logic [15:0] pctarget;
  logic        pc_en;
  logic        ir_en;
  logic        flush;
  logic        pcsrc_out;
  logic [15:0] pctarget_out;

  modport master (
    output halt_dec, hazard, pcsrc, pctarget,
    input  pc_en, ir_en, flush, pcsrc_out, pctarget_out
  );

  modport slave (
    input  halt_dec, hazard, pcsrc, pctarget,
    output pc_en, ir_en, flush, pcsrc_out, pctarget_out
  );
endinterface

// File: rtl/pipe_ctrl_edge_det.sv
// Rising-edge detector: one registered copy of the input, pulse while input is new-high.
module edge_det (
  input  logic clock4,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic q_r;

  // Previous-cycle copy of the input
  always_ff @(posedge clock4) begin
    if (reset) begin
      q_r <= 1'b0;
    end else begin
      q_r <= d;
    end
  end

  assign rise = d & ~q_r;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control FSM sequencing fetch through run/stall/flush/halt.
// Define PIPE_CTRL_SINGLE_STEP_EN to compile in single-step support.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT
) (
  input  logic        clock4,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  pipe_ctrl_if.slave  pif,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] fetch_cnt
);
`ifdef PIPE_CTRL_SINGLE_STEP_EN
  localparam logic STEP_EN = 1'b1;
`else
  localparam logic STEP_EN = 1'b0;
`endif
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

  state_code_t state_r, state_nxt_s;
  logic [2:0]  cnt_r, cnt_nxt_s;
  logic        step_flush_r, step_flush_nxt_s;
  logic [15:0] fetch_cnt_r;
  logic        run_rise_s, step_rise_s;
  logic        pc_en_s, ir_en_s, flush_s, pcsrc_out_s, halted_s;
  logic [15:0] pctarget_out_s;

  edge_det u_run_edge  (.clock4(clock4), .reset(reset), .d(run),  .rise(run_rise_s));
  edge_det u_step_edge (.clock4(clock4), .reset(reset), .d(step), .rise(step_rise_s));

  // Next-state and same-cycle pipeline enables
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    step_flush_nxt_s = step_flush_r;
    pc_en_s          = 1'b0;
    ir_en_s          = 1'b0;
    flush_s          = 1'b0;
    pcsrc_out_s      = 1'b0;
    pctarget_out_s   = 16'd0;
    halted_s         = 1'b0;
    case (state_r)
      S_IDLE, S_HALT: begin
        halted_s = (state_r == S_HALT);
        if (run_rise_s) begin
          state_nxt_s = S_RUN;
        end else if (STEP_EN && step_rise_s) begin
          state_nxt_s = S_STEP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_RUN, S_STALL: begin
        if (pif.halt_dec) begin
          state_nxt_s = S_HALT;
        end else if (pif.pcsrc) begin
          pc_en_s          = 1'b1;
          ir_en_s          = 1'b1;
          pcsrc_out_s      = 1'b1;
          pctarget_out_s   = pif.pctarget;
          cnt_nxt_s        = FLUSH_LOAD;
          step_flush_nxt_s = 1'b0;
          state_nxt_s      = S_FLUSH;
        end else if (pif.hazard) begin
          state_nxt_s = S_STALL;
        end else begin
          pc_en_s     = 1'b1;
          ir_en_s     = 1'b1;
          state_nxt_s = S_RUN;
        end
      end
      S_FLUSH: begin
        flush_s = 1'b1;
        pc_en_s = 1'b1;
        // A branch inside the bubble window restarts it; halt_dec here belongs to a squashed slot
        if (pif.pcsrc) begin
          pcsrc_out_s    = 1'b1;
          pctarget_out_s = pif.pctarget;
          cnt_nxt_s      = FLUSH_LOAD;
        end else if (cnt_r <= 3'd1) begin
          cnt_nxt_s        = 3'd0;
          step_flush_nxt_s = 1'b0;
          state_nxt_s      = step_flush_r ? S_HALT : S_RUN;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      S_STEP: begin
        if (STEP_EN) begin
          pc_en_s = 1'b1;
          ir_en_s = 1'b1;
          if (pif.pcsrc && !pif.halt_dec) begin
            pcsrc_out_s      = 1'b1;
            pctarget_out_s   = pif.pctarget;
            cnt_nxt_s        = FLUSH_LOAD;
            step_flush_nxt_s = 1'b1;
            state_nxt_s      = S_FLUSH;
          end else begin
            state_nxt_s = S_HALT;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        cnt_nxt_s        = 3'd0;
        step_flush_nxt_s = 1'b0;
        state_nxt_s      = S_IDLE;
      end
    endcase
  end

  // State, flush counter and fetch counter registers
  always_ff @(posedge clock4) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= 3'd0;
      step_flush_r <= 1'b0;
      fetch_cnt_r  <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      step_flush_r <= step_flush_nxt_s;
      if (pc_en_s) begin
        fetch_cnt_r <= fetch_cnt_r + 16'd1;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
    end
  end

  // Reset holds every pipeline-facing output low regardless of the current state
  assign pif.pc_en        = pc_en_s & ~reset;
  assign pif.ir_en        = ir_en_s & ~reset;
  assign pif.flush        = flush_s & ~reset;
  assign pif.pcsrc_out    = pcsrc_out_s & ~reset;
  assign pif.pctarget_out = reset ? 16'd0 : pctarget_out_s;
  assign halted           = halted_s & ~reset;
  assign state            = state_r;
  assign fetch_cnt        = fetch_cnt_r;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all compared each cycle against a behavioural model of the controller.
module tb_pipe_ctrl;
  localparam int FD = 2;
`ifdef PIPE_CTRL_SINGLE_STEP_EN
  localparam bit STEP_BUILD = 1'b1;
`else
  localparam bit STEP_BUILD = 1'b0;
`endif

  logic        clock4 = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] fetch_cnt;
  pipe_ctrl_if pif ();

  pipe_ctrl #(.FLUSH_DEPTH(FD)) dut (
    .clock4(clock4), .reset(reset), .run(run), .step(step),
    .pif(pif), .halted(halted), .state(state), .fetch_cnt(fetch_cnt)
  );

  always #5 clock4 = ~clock4;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: mode is the spec state code, m_left the bubbles still owed in FLUSH
  int          m_mode = 0;
  int          m_left = 0;
  bit          m_from_step = 1'b0;
  bit          m_prev_run = 1'b0;
  bit          m_prev_step = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval(output bit e_pc, output bit e_ir, output bit e_fl, output bit e_ps,
                            output logic [15:0] e_tgt, output bit e_hl, output int nxt);
    bit rr, sr;
    rr = run && !m_prev_run;
    sr = STEP_BUILD && step && !m_prev_step;
    e_pc = 0; e_ir = 0; e_fl = 0; e_ps = 0; e_tgt = 16'd0; e_hl = 0;
    nxt = m_mode;
    if (m_mode == 0) begin
      nxt = rr ? 1 : (sr ? 5 : 0);
    end else if (m_mode == 1 || m_mode == 2) begin
      if (pif.halt_dec) nxt = 4;
      else if (pif.pcsrc) begin
        e_pc = 1; e_ir = 1; e_ps = 1; e_tgt = pif.pctarget; nxt = 3;
      end else if (pif.hazard) nxt = 2;
      else begin
        e_pc = 1; e_ir = 1; nxt = 1;
      end
    end else if (m_mode == 3) begin
      e_fl = 1; e_pc = 1;
      if (pif.pcsrc) begin
        e_ps = 1; e_tgt = pif.pctarget;
      end
      nxt = (pif.pcsrc || m_left > 1) ? 3 : (m_from_step ? 4 : 1);
    end else if (m_mode == 4) begin
      e_hl = 1;
      nxt = rr ? 1 : (sr ? 5 : 4);
    end else if (m_mode == 5) begin
      e_pc = 1; e_ir = 1;
      if (pif.pcsrc && !pif.halt_dec) begin
        e_ps = 1; e_tgt = pif.pctarget; nxt = 3;
      end else nxt = 4;
    end else begin
      nxt = 0;
    end
    if (reset) begin
      e_pc = 0; e_ir = 0; e_fl = 0; e_ps = 0; e_tgt = 16'd0; e_hl = 0;
    end
  endtask

  // Model advance on each active edge
  always @(posedge clock4) begin : model_adv
    bit e_pc, e_ir, e_fl, e_ps, e_hl;
    logic [15:0] e_tgt;
    int nxt;
    model_eval(e_pc, e_ir, e_fl, e_ps, e_tgt, e_hl, nxt);
    if (reset) begin
      m_mode = 0; m_left = 0; m_from_step = 0; m_cnt = 16'd0;
      m_prev_run = 0; m_prev_step = 0;
    end else begin
      if (e_pc) m_cnt = m_cnt + 16'd1;
      if (nxt == 3) begin
        if (m_mode != 3) begin
          m_left = FD; m_from_step = (m_mode == 5);
        end else if (pif.pcsrc) m_left = FD;
        else m_left = m_left - 1;
      end else begin
        m_left = 0; m_from_step = 0;
      end
      m_mode = nxt;
      m_prev_run = run; m_prev_step = step;
    end
  end

  // Compare process, mid low phase of the clock
  always @(negedge clock4) begin : compare
    bit e_pc, e_ir, e_fl, e_ps, e_hl;
    logic [15:0] e_tgt;
    int nxt;
    #2;
    if (chk_en) begin
      model_eval(e_pc, e_ir, e_fl, e_ps, e_tgt, e_hl, nxt);
      chk("pc_en", 32'(pif.pc_en), 32'(e_pc));
      chk("ir_en", 32'(pif.ir_en), 32'(e_ir));
      chk("flush", 32'(pif.flush), 32'(e_fl));
      chk("pcsrc_out", 32'(pif.pcsrc_out), 32'(e_ps));
      chk("pctarget_out", 32'(pif.pctarget_out), 32'(e_tgt));
      chk("halted", 32'(halted), 32'(e_hl));
      chk("state", 32'(state), 32'(m_mode));
      chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
    end
  end

  task automatic drv(input logic r, input logic s, input logic h, input logic z,
                     input logic p, input logic [15:0] t, input logic rs);
    @(negedge clock4);
    run = r; step = s; pif.halt_dec = h; pif.hazard = z; pif.pcsrc = p;
    pif.pctarget = t; reset = rs;
    #3;
  endtask

  initial begin
    logic [15:0] f0;
    pif.halt_dec = 1'b0; pif.hazard = 1'b0; pif.pcsrc = 1'b0; pif.pctarget = 16'd0;
    drv(0, 0, 0, 0, 0, 16'd0, 1);
    chk_en = 1'b1;
    drv(0, 0, 0, 0, 0, 16'hBEEF, 1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fetch", 32'(fetch_cnt), 32'd0);
    chk("rst_tgt", 32'(pif.pctarget_out), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Run pulse then five fetch cycles
    drv(1, 0, 0, 0, 0, 16'd0, 0);
    chk("idle_pc_en", 32'(pif.pc_en), 32'd0);
    repeat (5) begin
      drv(0, 0, 0, 0, 0, 16'd0, 0);
      chk("run_pc_en", 32'(pif.pc_en), 32'd1);
    end
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    chk("fetch_5", 32'(fetch_cnt), 32'd5);

    // Taken branch with two bubbles
    drv(0, 0, 0, 0, 1, 16'h0010, 0);
    chk("br_pcsrc_out", 32'(pif.pcsrc_out), 32'd1);
    chk("br_target", 32'(pif.pctarget_out), 32'h10);
    drv(0, 0, 0, 0, 0, 16'h0010, 0);
    chk("fl1_state", 32'(state), 32'd3);
    chk("fl1_flush", 32'(pif.flush), 32'd1);
    chk("fl1_target", 32'(pif.pctarget_out), 32'd0);
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    chk("fl2_flush", 32'(pif.flush), 32'd1);
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    chk("fl_done_state", 32'(state), 32'd1);

    // Three hazard cycles
    drv(0, 0, 0, 1, 0, 16'd0, 0);
    f0 = fetch_cnt;
    chk("hz1_pc_en", 32'(pif.pc_en), 32'd0);
    drv(0, 0, 0, 1, 0, 16'd0, 0);
    chk("hz2_pc_en", 32'(pif.pc_en), 32'd0);
    drv(0, 0, 0, 1, 0, 16'd0, 0);
    chk("hz3_pc_en", 32'(pif.pc_en), 32'd0);
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    chk("hz_frozen", 32'(fetch_cnt), 32'(f0));
    chk("hz_resume_pc_en", 32'(pif.pc_en), 32'd1);

    // Simultaneous halt/branch/hazard, then run held high
    drv(0, 0, 1, 1, 1, 16'h1234, 0);
    chk("pri_pcsrc_out", 32'(pif.pcsrc_out), 32'd0);
    chk("pri_pc_en", 32'(pif.pc_en), 32'd0);
    drv(1, 0, 0, 0, 0, 16'd0, 0);
    chk("pri_halt", 32'(state), 32'd4);
    drv(1, 0, 1, 0, 0, 16'd0, 0);
    chk("resume_once", 32'(state), 32'd1);
    repeat (8) drv(1, 0, 0, 0, 0, 16'd0, 0);
    chk("level_no_resume", 32'(state), 32'd4);

    // Step pulses from HALT
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    f0 = fetch_cnt;
    repeat (2) begin
      drv(0, 1, 0, 0, 0, 16'd0, 0);
      drv(0, 0, 0, 0, 0, 16'd0, 0);
      chk("step_state", 32'(state), STEP_BUILD ? 32'd5 : 32'd4);
      drv(0, 0, 0, 0, 0, 16'd0, 0);
      chk("step_halted", 32'(halted), 32'd1);
    end
    chk("step_fetch", 32'(fetch_cnt), STEP_BUILD ? 32'(f0 + 16'd2) : 32'(f0));

    // Reset in the last bubble cycle
    drv(1, 0, 0, 0, 0, 16'd0, 0);
    drv(0, 0, 0, 0, 1, 16'h0005, 0);
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    drv(0, 0, 0, 0, 0, 16'd0, 1);
    chk("rst_fl_flush", 32'(pif.flush), 32'd0);
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    chk("rst_fl_state", 32'(state), 32'd0);
    chk("rst_fl_fetch", 32'(fetch_cnt), 32'd0);

    // Fetch counter wrap
    drv(1, 0, 0, 0, 0, 16'd0, 0);
    repeat (65535) drv(0, 0, 0, 0, 0, 16'd0, 0);
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    chk("fetch_ffff", 32'(fetch_cnt), 32'hFFFF);
    drv(0, 0, 0, 0, 0, 16'd0, 0);
    chk("fetch_wrap", 32'(fetch_cnt), 32'd0);

    // Randomized phase
    repeat (2000) begin
      drv(1'($urandom_range(3) == 0) ? ~run : run,
          1'($urandom_range(3) == 0) ? ~step : step,
          1'($urandom_range(15) == 0),
          1'($urandom_range(3) == 0),
          1'($urandom_range(5) == 0),
          16'($urandom),
          1'($urandom_range(63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2, bubble cycles inserted after a taken branch (legal 1..7).
REQ-002 clock4  in  1  pipeline advance clock; all state updates on posedge.
REQ-003 reset  in  1  reset, synchronous, active-high; clock clock4.
REQ-004 run  in  1  start/resume request; only its rising edge (sampled on clock4) acts.
REQ-005 step  in  1  single-step request; only its rising edge acts.
REQ-006 halt_dec  in  1  HLT instruction decoded this cycle.
REQ-007 hazard  in  1  load-use hazard; fetch must hold.
REQ-008 pcsrc  in  1  branch taken this cycle.
REQ-009 pctarget  in  16  branch offset for the fetch stage.
REQ-010 pc_en  out  1  fetch stage may advance PC.
REQ-011 ir_en  out  1  instruction register may load.
REQ-012 flush  out  1  downstream stages insert a bubble.
REQ-013 pcsrc_out  out  1  qualified branch select to the fetch stage.
REQ-014 pctarget_out  out  16  offset to the fetch stage; equals pctarget when pcsrc_out=1, else 0.
REQ-015 halted  out  1  high in HALT.
REQ-016 state  out  3  current state code.
REQ-017 fetch_cnt  out  16  instructions fetched (cycles with pc_en=1).

Function
REQ-018 States SHALL be IDLE=0, RUN=1, STALL=2, FLUSH=3, HALT=4, STEP=5; codes 6/7 SHALL go to IDLE next cycle.
REQ-019 run_rise/step_rise SHALL be detected with one registered copy of each input; a level held high SHALL act once.
REQ-020 IDLE: all enables 0; run_rise -> RUN.
REQ-021 RUN input priority SHALL be halt_dec > pcsrc > hazard, evaluated combinationally in the same cycle.
REQ-022 RUN, halt_dec=1: pc_en=0, ir_en=0; next HALT.
REQ-023 RUN, pcsrc=1: pc_en=1, ir_en=1, pcsrc_out=1, pctarget_out=pctarget; next FLUSH, flush counter loaded FLUSH_DEPTH.
REQ-024 RUN, hazard=1: pc_en=0, ir_en=0; next STALL.
REQ-025 RUN, none asserted: pc_en=1, ir_en=1; stay RUN.
REQ-026 STALL: pc_en=0, ir_en=0 while hazard=1; hazard=0 -> RUN same-cycle enables 1; pcsrc or halt_dec in STALL SHALL follow RUN rules (REQ-021..023).
REQ-027 FLUSH: flush=1, pc_en=1, ir_en=0, counter decrements each cycle; counter reaching 1 -> RUN next; hazard ignored.
REQ-028 FLUSH, pcsrc=1: pcsrc_out=1, counter reloads FLUSH_DEPTH; halt_dec ignored (squashed instruction).
REQ-029 HALT: halted=1, enables 0; run_rise -> RUN; step_rise handled per REQ-036.
REQ-030 pcsrc_out SHALL be 0 in every state/case other than REQ-023/REQ-028.
REQ-031 fetch_cnt SHALL increment on each posedge with pc_en=1, wrapping 0xFFFF -> 0x0000.

Reset
REQ-032 reset=1 on posedge SHALL force state=IDLE, flush counter=0, fetch_cnt=0, edge registers=0, overriding all inputs including mid-FLUSH/STALL.
REQ-033 While in reset state all outputs SHALL be 0 (pctarget_out=0, halted=0).

Configuration
REQ-034 Macro PIPE_CTRL_SINGLE_STEP_EN SHALL compile single-step support in.
REQ-035 Without the macro, step SHALL be ignored and STEP unreachable.
REQ-036 With the macro: step_rise in IDLE or HALT -> STEP; STEP asserts pc_en=1, ir_en=1 for exactly one cycle, then HALT; pcsrc in STEP -> FLUSH per REQ-023, then HALT instead of RUN.

Structure
REQ-037 Package pipe_ctrl_pkg SHALL hold the state enum codes and FLUSH_DEPTH default.
REQ-038 One sub-module edge_det (rising-edge detector, reused for run and step) SHALL be used; no other hierarchy.

Verification
REQ-039 Reset, run pulse, 5 idle cycles -> RUN, pc_en=1 each cycle, fetch_cnt=5.
REQ-040 RUN, pcsrc=1 with pctarget=0x0010, FLUSH_DEPTH=2 -> pcsrc_out=1/pctarget_out=0x0010 one cycle, flush=1 two cycles, then RUN.
REQ-041 RUN, hazard=1 three cycles -> pc_en=0 three cycles, fetch_cnt frozen, RUN resumes cycle hazard drops.
REQ-042 halt_dec=1, pcsrc=1, hazard=1 simultaneously -> HALT, pcsrc_out=0; run held high 10 cycles -> single resume.
REQ-043 With macro, HALT, two step pulses -> fetch_cnt +2, halted returns to 1 after each.
REQ-044 reset during FLUSH (counter=1) -> state=IDLE, flush=0 next cycle; fetch_cnt preset 0xFFFF plus one fetch -> 0x0000.
